// File: rtl/ist_leaf_scheduler_if.sv
// Request/response bundle between the traversal controller and the
// leaf scheduler: ray + leaf range in, closest hit out.
//
// master: traversal controller side (drives req_*, resp_ready)
// slave : scheduler side (drives req_ready, resp_*)
interface ist_leaf_scheduler_if #(
    parameter int IDX_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [95:0]      req_origin;
    logic [95:0]      req_dir;
    logic [31:0]      req_tmax;
    logic [IDX_W-1:0] req_first;
    logic [IDX_W-1:0] req_count;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_idx;
    logic [31:0]      resp_t;
    logic [31:0]      resp_u;
    logic [31:0]      resp_v;

    modport master (
        output req_valid, req_origin, req_dir, req_tmax,
        output req_first, req_count, resp_ready,
        input  req_ready, resp_valid, resp_hit,
        input  resp_idx, resp_t, resp_u, resp_v
    );

    modport slave (
        input  req_valid, req_origin, req_dir, req_tmax,
        input  req_first, req_count, resp_ready,
        output req_ready, resp_valid, resp_hit,
        output resp_idx, resp_t, resp_u, resp_v
    );
endinterface

// File: rtl/ist_leaf_scheduler.sv
// Leaf scheduler: walks a contiguous triangle range through one ist unit,
// shrinking tmax on every hit, and returns the closest hit.
//
// Ports: clk, reset (sync, active-high); bus (req/resp handshake, slave);
//   tri_ren/tri_raddr/tri_rdata: triangle RAM read port (fixed latency);
//   ist_valid + ist_* operands out, ist_done/intersected/t/u/v in.
module ist_leaf_scheduler #(
    parameter int IDX_W       = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    ist_leaf_scheduler_if.slave bus,
    output logic             tri_ren,
    output logic [IDX_W-1:0] tri_raddr,
    input  logic [479:0]     tri_rdata,
    output logic             ist_valid,
    output logic [31:0]      ist_origin_x,
    output logic [31:0]      ist_origin_y,
    output logic [31:0]      ist_origin_z,
    output logic [31:0]      ist_dir_x,
    output logic [31:0]      ist_dir_y,
    output logic [31:0]      ist_dir_z,
    output logic [31:0]      ist_tmax,
    output logic [31:0]      ist_p0_x,
    output logic [31:0]      ist_p0_y,
    output logic [31:0]      ist_p0_z,
    output logic [31:0]      ist_e1_x,
    output logic [31:0]      ist_e1_y,
    output logic [31:0]      ist_e1_z,
    output logic [31:0]      ist_e2_x,
    output logic [31:0]      ist_e2_y,
    output logic [31:0]      ist_e2_z,
    output logic [31:0]      ist_n_x,
    output logic [31:0]      ist_n_y,
    output logic [31:0]      ist_n_z,
    input  logic             ist_done,
    input  logic             ist_intersected,
    input  logic [31:0]      ist_t,
    input  logic [31:0]      ist_u,
    input  logic [31:0]      ist_v
);

    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_WAIT_IST,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [95:0]      origin_q;
    logic [95:0]      dir_q;
    logic [31:0]      tmax_q;
    logic [479:0]     tri_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] remaining_q;
    logic [LW-1:0]    lat_q;
    logic             hit_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [31:0]      best_t_q;
    logic [31:0]      best_u_q;
    logic [31:0]      best_v_q;

    logic req_ready_c;
    logic resp_valid_c;
    logic accept;
    logic ist_fin;

    assign accept  = (state == S_IDLE) && bus.req_valid;
    assign ist_fin = (state == S_WAIT_IST) && ist_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        tri_ren      = 1'b0;
        ist_valid    = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req_count == '0) begin
                        state_n = S_RESP;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                tri_ren = 1'b1;
                state_n = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (lat_q == '0) begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ist_valid = 1'b1;
                state_n   = S_WAIT_IST;
            end
            S_WAIT_IST: begin
                if (ist_done) begin
                    // remaining is nonzero here, so 1 means this was the last
                    if (remaining_q == IDX_W'(1)) begin
                        state_n = S_RESP;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end
            S_RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            origin_q    <= '0;
            dir_q       <= '0;
            tmax_q      <= '0;
            tri_q       <= '0;
            idx_q       <= '0;
            remaining_q <= '0;
            lat_q       <= '0;
            hit_q       <= 1'b0;
            best_idx_q  <= '0;
            best_t_q    <= '0;
            best_u_q    <= '0;
            best_v_q    <= '0;
        end else begin
            if (accept) begin
                origin_q    <= bus.req_origin;
                dir_q       <= bus.req_dir;
                tmax_q      <= bus.req_tmax;
                idx_q       <= bus.req_first;
                remaining_q <= bus.req_count;
                hit_q       <= 1'b0;
                best_idx_q  <= '0;
                best_t_q    <= '0;
                best_u_q    <= '0;
                best_v_q    <= '0;
            end
            if (state == S_FETCH) begin
                lat_q <= LW'(MEM_LATENCY - 1);
            end
            // Capture lands exactly MEM_LATENCY cycles after FETCH
            if (state == S_WAIT_MEM) begin
                if (lat_q == '0) begin
                    tri_q <= tri_rdata;
                end else begin
                    lat_q <= lat_q - LW'(1);
                end
            end
            if (ist_fin) begin
                // ist tests t < tmax, so equal-t later triangles never win
                if (ist_intersected) begin
                    tmax_q     <= ist_t;
                    best_t_q   <= ist_t;
                    best_u_q   <= ist_u;
                    best_v_q   <= ist_v;
                    best_idx_q <= idx_q;
                    hit_q      <= 1'b1;
                end
                idx_q       <= idx_q + IDX_W'(1);
                remaining_q <= remaining_q - IDX_W'(1);
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_hit   = hit_q;
    assign bus.resp_idx   = best_idx_q;
    assign bus.resp_t     = best_t_q;
    assign bus.resp_u     = best_u_q;
    assign bus.resp_v     = best_v_q;

    assign tri_raddr = idx_q;

    assign ist_origin_x = origin_q[31:0];
    assign ist_origin_y = origin_q[63:32];
    assign ist_origin_z = origin_q[95:64];
    assign ist_dir_x    = dir_q[31:0];
    assign ist_dir_y    = dir_q[63:32];
    assign ist_dir_z    = dir_q[95:64];
    assign ist_tmax     = tmax_q;

    assign ist_p0_x = tri_q[0*32 +: 32];
    assign ist_p0_y = tri_q[1*32 +: 32];
    assign ist_p0_z = tri_q[2*32 +: 32];
    assign ist_e1_x = tri_q[3*32 +: 32];
    assign ist_e1_y = tri_q[4*32 +: 32];
    assign ist_e1_z = tri_q[5*32 +: 32];
    assign ist_e2_x = tri_q[6*32 +: 32];
    assign ist_e2_y = tri_q[7*32 +: 32];
    assign ist_e2_z = tri_q[8*32 +: 32];
    assign ist_n_x  = tri_q[9*32 +: 32];
    assign ist_n_y  = tri_q[10*32 +: 32];
    assign ist_n_z  = tri_q[11*32 +: 32];

endmodule

// File: tb/tb_ist_leaf_scheduler.sv
// Bench for ist_leaf_scheduler: RAM model, stand-in ist unit and a
// range-level reference model of the closest-hit search.
module tb_ist_leaf_scheduler;

    localparam int IDX_W = 16;
    localparam int L     = 2;

    localparam logic [31:0] F1   = 32'h3F800000;
    localparam logic [31:0] F01  = 32'h3DCCCCCD;
    localparam logic [31:0] F3   = 32'h40400000;
    localparam logic [31:0] F5   = 32'h40A00000;
    localparam logic [31:0] F8   = 32'h41000000;
    localparam logic [31:0] F100 = 32'h42C80000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ist_leaf_scheduler_if #(.IDX_W(IDX_W)) bus ();

    logic             tri_ren;
    logic [IDX_W-1:0] tri_raddr;
    logic [479:0]     tri_rdata;
    logic             ist_valid;
    logic [31:0] ist_origin_x, ist_origin_y, ist_origin_z;
    logic [31:0] ist_dir_x, ist_dir_y, ist_dir_z, ist_tmax;
    logic [31:0] ist_p0_x, ist_p0_y, ist_p0_z;
    logic [31:0] ist_e1_x, ist_e1_y, ist_e1_z;
    logic [31:0] ist_e2_x, ist_e2_y, ist_e2_z;
    logic [31:0] ist_n_x, ist_n_y, ist_n_z;
    logic        ist_done, ist_intersected;
    logic [31:0] ist_t, ist_u, ist_v;

    ist_leaf_scheduler #(.IDX_W(IDX_W), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .tri_ren(tri_ren), .tri_raddr(tri_raddr), .tri_rdata(tri_rdata),
        .ist_valid(ist_valid),
        .ist_origin_x(ist_origin_x), .ist_origin_y(ist_origin_y),
        .ist_origin_z(ist_origin_z),
        .ist_dir_x(ist_dir_x), .ist_dir_y(ist_dir_y), .ist_dir_z(ist_dir_z),
        .ist_tmax(ist_tmax),
        .ist_p0_x(ist_p0_x), .ist_p0_y(ist_p0_y), .ist_p0_z(ist_p0_z),
        .ist_e1_x(ist_e1_x), .ist_e1_y(ist_e1_y), .ist_e1_z(ist_e1_z),
        .ist_e2_x(ist_e2_x), .ist_e2_y(ist_e2_y), .ist_e2_z(ist_e2_z),
        .ist_n_x(ist_n_x), .ist_n_y(ist_n_y), .ist_n_z(ist_n_z),
        .ist_done(ist_done), .ist_intersected(ist_intersected),
        .ist_t(ist_t), .ist_u(ist_u), .ist_v(ist_v)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- triangle RAM model ----------------
    logic [479:0]     mem [0:255];
    logic [479:0]     pd  [0:L-1];
    logic             pv  [0:L-1];
    logic [IDX_W-1:0] ren_q [$];

    always @(posedge clk) begin
        pv[0] <= tri_ren;
        pd[0] <= mem[tri_raddr[7:0]];
        for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        if (tri_ren) ren_q.push_back(tri_raddr);
    end

    assign tri_rdata = (pv[L-1] === 1'b1) ? pd[L-1] : {15{32'hDEADBEEF}};

    // ---------------- stand-in ist unit ----------------
    // Hit distance is p0_z, u/v are p0_x/p0_y, a nonzero n_x forces a miss.
    int          lat_max = 3;
    logic        m_done = 1'b0, m_int = 1'b0;
    logic [31:0] m_t = '0, m_u = '0, m_v = '0;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [479:0] op_tri;
    logic [191:0] op_ray;
    logic [31:0]  op_tmax;
    int          stab_err = 0;
    logic        inj_done = 1'b0;
    logic [479:0] iss_tri_q [$];
    logic [191:0] iss_ray_q [$];
    logic [31:0]  iss_tmax_q [$];

    wire [479:0] cur_tri = {ist_n_z, ist_n_y, ist_n_x,
                            ist_e2_z, ist_e2_y, ist_e2_x,
                            ist_e1_z, ist_e1_y, ist_e1_x,
                            ist_p0_z, ist_p0_y, ist_p0_x};
    wire [191:0] cur_ray = {ist_dir_z, ist_dir_y, ist_dir_x,
                            ist_origin_z, ist_origin_y, ist_origin_x};

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (reset) begin
            busy <= 1'b0;
        end else if (ist_valid) begin
            busy    <= 1'b1;
            cnt     <= int'($urandom_range(0, lat_max));
            op_tri  <= cur_tri;
            op_ray  <= cur_ray;
            op_tmax <= ist_tmax;
            iss_tri_q.push_back(cur_tri);
            iss_ray_q.push_back(cur_ray);
            iss_tmax_q.push_back(ist_tmax);
        end else if (busy) begin
            if ({cur_tri, cur_ray, ist_tmax} !== {op_tri, op_ray, op_tmax})
                stab_err++;
            if (cnt == 0) begin
                busy   <= 1'b0;
                m_done <= 1'b1;
                m_t    <= op_tri[64 +: 32];
                m_u    <= op_tri[0 +: 32];
                m_v    <= op_tri[32 +: 32];
                m_int  <= (op_tri[288 +: 32] == 32'h0) &&
                          (op_tri[64 +: 32] < op_tmax);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    assign ist_done        = m_done | inj_done;
    assign ist_intersected = inj_done ? 1'b1 : m_int;
    assign ist_t           = inj_done ? F1 : m_t;
    assign ist_u           = inj_done ? F1 : m_u;
    assign ist_v           = inj_done ? F1 : m_v;

    // ---------------- reference model ----------------
    // Positive floats order like unsigned integers, so plain < suffices.
    logic [IDX_W-1:0] exp_addr_q [$];
    logic [31:0]      exp_tmax_q [$];
    logic             e_hit;
    logic [IDX_W-1:0] e_idx;
    logic [31:0]      e_t, e_u, e_v;

    task automatic ref_model(input logic [IDX_W-1:0] first,
                             input logic [IDX_W-1:0] count,
                             input logic [31:0] tmax);
        logic [31:0]      cur;
        logic [IDX_W-1:0] a;
        logic [479:0]     tr;
        cur = tmax;
        e_hit = 1'b0; e_idx = '0; e_t = '0; e_u = '0; e_v = '0;
        exp_addr_q.delete();
        exp_tmax_q.delete();
        for (int i = 0; i < int'(count); i++) begin
            a = IDX_W'(int'(first) + i);
            tr = mem[a[7:0]];
            exp_addr_q.push_back(a);
            exp_tmax_q.push_back(cur);
            if (tr[288 +: 32] == 32'h0 && tr[64 +: 32] < cur) begin
                e_hit = 1'b1;
                e_idx = a;
                cur   = tr[64 +: 32];
                e_t   = tr[64 +: 32];
                e_u   = tr[0 +: 32];
                e_v   = tr[32 +: 32];
            end
        end
    endtask

    function automatic logic [479:0] mk_tri(input logic [31:0] z,
                                            input logic miss,
                                            input logic [31:0] u,
                                            input logic [31:0] v);
        logic [479:0] r;
        r = '0;
        r[0 +: 32]   = u;
        r[32 +: 32]  = v;
        r[64 +: 32]  = z;
        r[96 +: 32]  = F1;
        r[224 +: 32] = F1;
        r[288 +: 32] = miss ? F1 : 32'h0;
        r[352 +: 32] = F1;
        return r;
    endfunction

    // ---------------- request driver ----------------
    logic             o_ok, o_hit;
    logic [IDX_W-1:0] o_idx;
    logic [31:0]      o_t, o_u, o_v;
    int               o_lat;

    task automatic do_req(input logic [IDX_W-1:0] first,
                          input logic [IDX_W-1:0] count,
                          input logic [31:0] tmax,
                          input logic [95:0] org,
                          input logic [95:0] dir,
                          input bit ack);
        int w;
        ren_q.delete();
        iss_tri_q.delete();
        iss_ray_q.delete();
        iss_tmax_q.delete();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_first  = first;
        bus.req_count  = count;
        bus.req_tmax   = tmax;
        bus.req_origin = org;
        bus.req_dir    = dir;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_first  = IDX_W'($urandom);
        bus.req_count  = IDX_W'($urandom);
        bus.req_tmax   = $urandom;
        bus.req_origin = {$urandom, $urandom, $urandom};
        bus.req_dir    = {$urandom, $urandom, $urandom};
        o_lat = 1;
        while (!bus.resp_valid && o_lat < 3000) begin
            @(negedge clk);
            o_lat++;
        end
        o_ok  = bus.resp_valid;
        o_hit = bus.resp_hit;
        o_idx = bus.resp_idx;
        o_t   = bus.resp_t;
        o_u   = bus.resp_u;
        o_v   = bus.resp_v;
        if (ack) begin
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
        checks++;
        if ({tri_ren, ist_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b want 00", {tri_ren, ist_valid});
        end
        checks++;
        if ({bus.resp_valid, bus.resp_hit} !== 2'b00) begin
            errors++; $display("FAIL reset_resp_flags: got %b want 00",
                               {bus.resp_valid, bus.resp_hit});
        end
        checks++;
        if ({bus.resp_idx, bus.resp_t, bus.resp_u, bus.resp_v} !== '0) begin
            errors++; $display("FAIL reset_resp_data: got %h want 0",
                               {bus.resp_idx, bus.resp_t, bus.resp_u, bus.resp_v});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        do_req(16'h0005, 16'h0000, F1, '0, {F1, F01, F01}, 1'b1);
        checks++;
        if (o_ok !== 1'b1 || o_lat != 1) begin
            errors++; $display("FAIL zero_latency: got ok=%b lat=%0d want ok=1 lat=1", o_ok, o_lat);
        end
        checks++;
        if ({o_hit, o_idx, o_t, o_u, o_v} !== '0) begin
            errors++; $display("FAIL zero_resp: got %h want 0", {o_hit, o_idx, o_t, o_u, o_v});
        end
        checks++;
        if (ren_q.size() != 0 || iss_tmax_q.size() != 0) begin
            errors++; $display("FAIL zero_pulses: got ren=%0d ist=%0d want 0 0",
                               ren_q.size(), iss_tmax_q.size());
        end
    endtask

    task automatic test_single();
        lat_max = 0;
        mem[8'h10] = mk_tri(F5, 1'b0, 32'h0, 32'h0);
        do_req(16'h0010, 16'h0001, F100, '0, {F1, F01, F01}, 1'b1);
        checks++;
        if (o_ok !== 1'b1 || o_lat != 7) begin
            errors++; $display("FAIL single_latency: got ok=%b lat=%0d want ok=1 lat=7", o_ok, o_lat);
        end
        checks++;
        if ({o_hit, o_idx, o_t} !== {1'b1, 16'h0010, F5}) begin
            errors++; $display("FAIL single_resp: got %h want %h",
                               {o_hit, o_idx, o_t}, {1'b1, 16'h0010, F5});
        end
        checks++;
        if (iss_tmax_q.size() != 1) begin
            errors++; $display("FAIL single_issues: got %0d want 1", iss_tmax_q.size());
        end else begin
            checks++;
            if ({iss_tri_q[0], iss_ray_q[0], iss_tmax_q[0]} !==
                {mem[8'h10], F1, F01, F01, 96'h0, F100}) begin
                errors++; $display("FAIL single_operands: got tmax=%h want %h",
                                   iss_tmax_q[0], F100);
            end
        end
        lat_max = 3;
    endtask

    task automatic test_two();
        mem[8'h20] = mk_tri(F8, 1'b0, 32'h1, 32'h2);
        mem[8'h21] = mk_tri(F5, 1'b0, 32'h3, 32'h4);
        do_req(16'h0020, 16'h0002, F100, '0, {F1, F01, F01}, 1'b1);
        checks++;
        if ({o_hit, o_idx, o_t, o_u, o_v} !== {1'b1, 16'h0021, F5, 32'h3, 32'h4}) begin
            errors++; $display("FAIL two_near_second: got %h want %h",
                               {o_hit, o_idx, o_t, o_u, o_v},
                               {1'b1, 16'h0021, F5, 32'h3, 32'h4});
        end
        checks++;
        if (iss_tmax_q.size() != 2 || iss_tmax_q[1] !== F8) begin
            errors++; $display("FAIL two_shrunk_tmax: got n=%0d tmax=%h want n=2 tmax=%h",
                               iss_tmax_q.size(), iss_tmax_q[iss_tmax_q.size()-1], F8);
        end
        mem[8'h30] = mk_tri(F5, 1'b0, 32'h5, 32'h6);
        mem[8'h31] = mk_tri(F8, 1'b0, 32'h7, 32'h8);
        do_req(16'h0030, 16'h0002, F100, '0, {F1, F01, F01}, 1'b1);
        checks++;
        if ({o_hit, o_idx, o_t, o_u, o_v} !== {1'b1, 16'h0030, F5, 32'h5, 32'h6}) begin
            errors++; $display("FAIL two_near_first: got %h want %h",
                               {o_hit, o_idx, o_t, o_u, o_v},
                               {1'b1, 16'h0030, F5, 32'h5, 32'h6});
        end
        checks++;
        if (iss_tmax_q.size() != 2 || iss_tmax_q[1] !== F5) begin
            errors++; $display("FAIL two_rev_tmax: got n=%0d want n=2 tmax=%h",
                               iss_tmax_q.size(), F5);
        end
    endtask

    task automatic test_wrap();
        mem[8'hFF] = mk_tri(F5, 1'b0, 32'h9, 32'hA);
        mem[8'h00] = mk_tri(F8, 1'b0, 32'hB, 32'hC);
        do_req(16'hFFFF, 16'h0002, F100, '0, {F1, F01, F01}, 1'b1);
        checks++;
        if (ren_q.size() != 2 || ren_q[0] !== 16'hFFFF || ren_q[1] !== 16'h0000) begin
            errors++; $display("FAIL wrap_addr: got n=%0d first=%h want FFFF,0000",
                               ren_q.size(), ren_q[0]);
        end
        checks++;
        if ({o_hit, o_idx, o_t} !== {1'b1, 16'hFFFF, F5}) begin
            errors++; $display("FAIL wrap_resp: got %h want %h",
                               {o_hit, o_idx, o_t}, {1'b1, 16'hFFFF, F5});
        end
    endtask

    task automatic test_backpressure();
        int bad;
        mem[8'h40] = mk_tri(F3, 1'b0, 32'h11, 32'h22);
        do_req(16'h0040, 16'h0001, F100, '0, {F1, F01, F01}, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({bus.resp_valid, bus.req_ready, bus.resp_hit, bus.resp_idx,
                 bus.resp_t, bus.resp_u, bus.resp_v} !==
                {2'b10, 1'b1, 16'h0040, F3, 32'h11, 32'h22}) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
            errors++; $display("FAIL hold_release: got %b want 01",
                               {bus.resp_valid, bus.req_ready});
        end
    endtask

    task automatic test_reset_mid();
        int w;
        lat_max = 5;
        mem[8'h50] = mk_tri(F5, 1'b0, 32'h0, 32'h0);
        mem[8'h51] = mk_tri(F8, 1'b0, 32'h33, 32'h44);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_first = 16'h0050;
        bus.req_count = 16'h0001;
        bus.req_tmax  = F100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        w = 0;
        while (ist_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (ist_valid !== 1'b1) begin
            errors++; $display("FAIL mid_issue_seen: got %b want 1", ist_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.req_ready, bus.resp_valid, tri_ren, ist_valid} !== 4'b1000) begin
            errors++; $display("FAIL mid_reset_idle: got %b want 1000",
                               {bus.req_ready, bus.resp_valid, tri_ren, ist_valid});
        end
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_hit} !== 3'b100) begin
            errors++; $display("FAIL mid_late_done: got %b want 100",
                               {bus.req_ready, bus.resp_valid, bus.resp_hit});
        end
        do_req(16'h0051, 16'h0001, F100, '0, {F1, F01, F01}, 1'b1);
        checks++;
        if ({o_ok, o_hit, o_idx, o_t, o_u, o_v} !==
            {2'b11, 16'h0051, F8, 32'h33, 32'h44}) begin
            errors++; $display("FAIL mid_after_reset: got %h want %h",
                               {o_ok, o_hit, o_idx, o_t, o_u, o_v},
                               {2'b11, 16'h0051, F8, 32'h33, 32'h44});
        end
        checks++;
        if (iss_tmax_q.size() != 1 || iss_tmax_q[0] !== F100) begin
            errors++; $display("FAIL mid_tmax_reload: got n=%0d want n=1 tmax=%h",
                               iss_tmax_q.size(), F100);
        end
        lat_max = 3;
    endtask

    task automatic test_random();
        logic [31:0]      zpool [4];
        logic [IDX_W-1:0] first, count;
        logic [31:0]      tmax;
        logic [95:0]      org, dir;
        int               bad;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 4; k++)
                zpool[k] = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
            for (int a = 0; a < 256; a++)
                mem[a] = mk_tri(zpool[$urandom_range(0, 3)],
                                ($urandom_range(0, 3) == 0),
                                $urandom, $urandom);
            first = ($urandom_range(0, 3) == 0) ? IDX_W'(16'hFFFF - $urandom_range(0, 3))
                                                : IDX_W'($urandom);
            count = IDX_W'($urandom_range(0, 6));
            tmax  = ($urandom_range(0, 1) == 1) ? zpool[$urandom_range(0, 3)] : F100;
            org   = {$urandom, $urandom, $urandom};
            dir   = {$urandom, $urandom, $urandom};
            lat_max = int'($urandom_range(0, 4));
            ref_model(first, count, tmax);
            do_req(first, count, tmax, org, dir, 1'b1);
            checks++;
            if ({o_ok, o_hit, o_idx, o_t, o_u, o_v} !==
                {1'b1, e_hit, e_idx, e_t, e_u, e_v}) begin
                errors++; $display("FAIL rand_resp[%0d]: got %h want %h", it,
                                   {o_ok, o_hit, o_idx, o_t, o_u, o_v},
                                   {1'b1, e_hit, e_idx, e_t, e_u, e_v});
            end
            bad = 0;
            if (ren_q.size() != exp_addr_q.size() ||
                iss_tmax_q.size() != exp_tmax_q.size()) begin
                bad = 1000;
            end else begin
                for (int i = 0; i < ren_q.size(); i++) begin
                    if (ren_q[i] !== exp_addr_q[i]) bad++;
                    if (iss_tmax_q[i] !== exp_tmax_q[i]) bad++;
                    if (iss_tri_q[i] !== mem[exp_addr_q[i][7:0]]) bad++;
                    if (iss_ray_q[i] !== {dir, org}) bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand_sequence[%0d]: got %0d bad entries want 0", it, bad);
            end
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL operand_stability: got %0d changes want 0", stab_err);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_origin = '0;
        bus.req_dir    = '0;
        bus.req_tmax   = '0;
        bus.req_first  = '0;
        bus.req_count  = '0;
        bus.resp_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        test_reset();
        test_zero_count();
        test_single();
        test_two();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ist_leaf_scheduler.md
Name: ist_leaf_scheduler

Overview:
Sequences the ray/triangle intersection unit (ist) over a contiguous range of triangles in a BVH leaf and returns the closest hit. It accepts one ray plus a leaf range, fetches each triangle record from triangle memory, and issues it to ist. Each accepted hit becomes the new tmax, so later triangles are tested against a shrinking interval. It sits between the traversal controller (request/response side) and one ist instance plus the triangle RAM read port.

Parameters:
IDX_W, 16, width of triangle index and triangle count
MEM_LATENCY, 2, fixed triangle RAM read latency in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  ray + leaf range offered
req_ready  out  1  scheduler idle, request accepted when req_valid & req_ready
req_origin  in  96  {z,y,x} float32 ray origin
req_dir  in  96  {z,y,x} float32 ray direction
req_tmax  in  32  float32 initial tmax
req_first  in  IDX_W  first triangle index
req_count  in  IDX_W  number of triangles (0 allowed)
tri_ren  out  1  triangle RAM read enable
tri_raddr  out  IDX_W  triangle RAM address
tri_rdata  in  480  {n_z,n_y,n_x,e2_z,e2_y,e2_x,e1_z,e1_y,e1_x,p0_z,p0_y,p0_x} float32, valid MEM_LATENCY cycles after tri_ren
ist_valid  out  1  start pulse to ist
ist_origin_x/y/z, ist_dir_x/y/z, ist_tmax  out  32 each  ray operands to ist
ist_p0_x/y/z, ist_e1_x/y/z, ist_e2_x/y/z, ist_n_x/y/z  out  32 each  triangle operands to ist
ist_done  in  1  ist completion pulse
ist_intersected  in  1  valid with ist_done
ist_t, ist_u, ist_v  in  32 each  ist results, valid with ist_done
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_hit  out  1  at least one triangle hit
resp_idx  out  IDX_W  index of closest hit triangle
resp_t, resp_u, resp_v  out  32 each  closest hit parameters

Behaviour:
- States: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_IST, RESP.
- Reset (synchronous, any state): go to IDLE. req_ready=1. tri_ren=0. ist_valid=0. resp_valid=0. resp_hit=0. resp_idx/t/u/v=0. Internal registers cleared. An in-flight ist operation is abandoned; ist shares the same reset.
- IDLE: req_ready=1.
  - On accept: latch origin, dir, tmax into the ray registers; idx=req_first; remaining=req_count; hit=0.
  - If req_count==0: go directly to RESP with hit=0, idx/t/u/v=0, so resp_valid rises the cycle after accept.
  - Otherwise go to FETCH.
- FETCH (1 cycle): tri_ren=1, tri_raddr=idx. Go to WAIT_MEM with latency counter = MEM_LATENCY-1.
- WAIT_MEM: count down. tri_rdata is captured into the triangle registers in the cycle exactly MEM_LATENCY cycles after the FETCH cycle. Then go to ISSUE.
- ISSUE (1 cycle): ist_valid=1. Go to WAIT_IST.
- Operand stability: all ist_* operand outputs come from registers. They must stay constant from ISSUE until the cycle ist_done is sampled, because ist reads operands across many internal states. ist_tmax = current best tmax register.
- WAIT_IST, when ist_done=1:
  - If ist_intersected: best_t=tmax=ist_t, best_u=ist_u, best_v=ist_v, best_idx=idx, hit=1.
  - idx=idx+1, wrapping modulo 2^IDX_W. remaining=remaining-1.
  - If the new remaining==0, go to RESP; else go to FETCH.
  - ist_done without a prior ISSUE (any other state) is ignored.
- Tie rule: ist tests t<tmax strictly, so an equal-t triangle later in the range never replaces the earlier one (first wins).
- RESP: resp_valid=1, resp_* held stable; req_ready=0. Return to IDLE on the cycle resp_valid & resp_ready; req_ready=1 the next cycle. No combinational req-to-resp path.
- Per-triangle cost: 1 (FETCH) + MEM_LATENCY + 1 (ISSUE) + ist latency cycles. No overlap between triangles.
- req_* changes while not in IDLE have no effect. tri_ren is asserted only in FETCH. ist_valid is asserted only in ISSUE.

Test Plan:
- req_count=0, tmax=1.0 -> resp_valid the cycle after accept, resp_hit=0, zero tri_ren and ist_valid pulses.
- One triangle p0=(0,0,5), e1=(1,0,0), e2=(0,1,0), ray origin 0, dir (0.1,0.1,1), tmax 100.0 -> one ist_valid; resp_hit=1, resp_t=5.0, resp_idx=req_first.
- Two triangles at z=8 then z=5, same ray -> second ist_tmax=8.0; resp_t=5.0, resp_idx=first+1. Reversed order -> second triangle misses (ist_tmax=5.0), resp_idx=first.
- Range first=2^IDX_W-1, count=2 -> tri_raddr sequence 0xFFFF then 0x0000.
- resp_ready held low 10 cycles -> resp_valid and resp_* stable, req_ready=0; then a one-cycle resp_ready returns to IDLE.
- reset asserted in WAIT_IST -> next cycle IDLE, req_ready=1, resp_valid=0. A late ist_done is ignored, and a new request completes correctly.
